// File: rtl/demux_1to31_lane.sv
// Registered 1-to-31 lane demux; optional pointer steering under DEMUX_AUTOINC_EN.
// Latency: one cycle from accepted word to lane output; no comb path inp->out_bus.
// Backpressure: in_ready drops only when the target lane is full and not being acked.
module demux_1to31_lane #(
  parameter int W     = 2,
  parameter int NLANE = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         sel,
  input  logic [W-1:0]       inp,
  input  logic               auto_mode,
  output logic [NLANE*W-1:0] out_bus,
  output logic [NLANE-1:0]   out_vld,
  input  logic [NLANE-1:0]   out_ack,
  output logic               err,
  output logic [7:0]         err_cnt
);

  logic [4:0]       tgt;
  logic             legal;
  logic             take;
  logic [31:0]      vld_ext;
  logic [31:0]      ack_ext;
  logic [NLANE-1:0] wr;

`ifdef DEMUX_AUTOINC_EN
  logic [4:0] ptr;

  assign tgt = auto_mode ? ptr : sel;

  // Pointer only walks 0..30, so auto mode can never address the drop code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 5'd0;
    end else if (take && auto_mode) begin
      ptr <= (ptr == 5'd30) ? 5'd0 : ptr + 5'd1;
    end
  end
`else
  logic unused_auto_mode;

  assign unused_auto_mode = auto_mode;
  assign tgt              = sel;
`endif

  // Zero-extended views let code 31 be indexed safely; it never stalls.
  assign vld_ext  = 32'(out_vld);
  assign ack_ext  = 32'(out_ack);
  assign legal    = (tgt != 5'd31);
  assign in_ready = ~legal | ~vld_ext[tgt] | ack_ext[tgt];
  assign take     = in_valid & in_ready;

  always_comb begin
    wr = '0;
    for (int n = 0; n < NLANE; n++) begin
      wr[n] = take && legal && (tgt == 5'(n));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_bus <= '0;
      out_vld <= '0;
    end else begin
      for (int n = 0; n < NLANE; n++) begin
        if (wr[n]) begin
          out_bus[n*W +: W] <= inp;
          out_vld[n]        <= 1'b1;
        end else if (out_ack[n]) begin
          out_vld[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= take & ~legal;
      if (take && !legal && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_1to31_lane.sv
// Scoreboard bench for demux_1to31_lane; auto-increment checks run when DEMUX_AUTOINC_EN is defined.
module tb_demux_1to31_lane;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  sel;
  logic [1:0]  inp;
  logic        auto_mode;
  logic [61:0] out_bus;
  logic [30:0] out_vld;
  logic [30:0] out_ack;
  logic        err;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         lane;
    logic [1:0] dat;
  } exp_t;
  exp_t sbq[$];

  logic [61:0] m_bus;
  logic [30:0] m_vld;
  logic        m_err;
  logic [7:0]  m_cnt;
  int          m_ptr;

  demux_1to31_lane #(.W(2), .NLANE(31)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .inp       (inp),
    .auto_mode (auto_mode),
    .out_bus   (out_bus),
    .out_vld   (out_vld),
    .out_ack   (out_ack),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bus = '0;
    m_vld = '0;
    m_err = 1'b0;
    m_cnt = 8'd0;
    m_ptr = 0;
    sbq.delete();
  endtask

  // Drive one cycle (called just after a rising edge), predict, then check after the next edge.
  task automatic cyc(input logic v, input logic [4:0] s, input logic [1:0] d,
                     input logic [30:0] ack, input logic am);
    int   t;
    logic rdy;
    exp_t e;
    in_valid  = v;
    sel       = s;
    inp       = d;
    out_ack   = ack;
    auto_mode = am;
`ifdef DEMUX_AUTOINC_EN
    t = am ? m_ptr : int'(s);
`else
    t = int'(s);
`endif
    if (t == 31) rdy = 1'b1;
    else         rdy = !m_vld[t] || ack[t];
    #1;
    chk("in_ready", in_ready, rdy);
    m_vld = m_vld & ~ack;
    m_err = 1'b0;
    if (v && rdy) begin
      if (t == 31) begin
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt++;
      end else begin
        m_vld[t]       = 1'b1;
        m_bus[t*2 +: 2] = d;
        e.lane = t;
        e.dat  = d;
        sbq.push_back(e);
      end
`ifdef DEMUX_AUTOINC_EN
      if (am) m_ptr = (m_ptr == 30) ? 0 : m_ptr + 1;
`endif
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("lane_vld", out_vld[e.lane], 1'b1);
      chk("lane_dat", out_bus[e.lane*2 +: 2], e.dat);
    end
    chk("out_vld", out_vld, m_vld);
    chk("out_bus", out_bus, m_bus);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_cnt);
  endtask

  initial begin
    in_valid  = 1'b0;
    sel       = 5'd0;
    inp       = 2'd0;
    out_ack   = '0;
    auto_mode = 1'b0;
    reset     = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_vld", out_vld, 31'h0);
    chk("rst_bus", out_bus, 62'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", err_cnt, 8'd0);
    // Under reset the lanes are empty so in_ready is high, but nothing is taken.
    in_valid = 1'b1;
    sel      = 5'd5;
    inp      = 2'b11;
    #1;
    chk("rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_no_take", out_vld, 31'h0);
    in_valid = 1'b0;
    reset    = 1'b0;

    // Single write into lane 5.
    cyc(1, 5'd5, 2'b10, '0, 0);
    chk("t1_vld", out_vld, 31'h20);
    chk("t1_dat", out_bus[11:10], 2'b10);

    // Full lane stalls, then ack on the same edge reloads it.
    cyc(1, 5'd5, 2'b11, '0, 0);
    chk("stall_ready", in_ready, 1'b0);
    chk("stall_dat", out_bus[11:10], 2'b10);
    cyc(1, 5'd5, 2'b01, 31'h20, 0);
    chk("reload_dat", out_bus[11:10], 2'b01);
    chk("reload_vld", out_vld[5], 1'b1);
    cyc(0, 5'd0, 2'b00, 31'h20, 0);
    chk("consume_vld", out_vld, 31'h0);
    chk("hold_dat", out_bus[11:10], 2'b01);

    // Drops on the illegal code.
    for (int i = 0; i < 3; i++) cyc(1, 5'd31, 2'b11, '0, 0);
    chk("drop3_cnt", err_cnt, 8'd3);
    chk("drop3_vld", out_vld, 31'h0);
    for (int i = 0; i < 300; i++) cyc(1, 5'd31, 2'(i), '0, 0);
    chk("sat_cnt", err_cnt, 8'd255);
    chk("sat_err", err, 1'b1);
    cyc(0, 5'd31, 2'b00, '0, 0);
    chk("err_clear", err, 1'b0);

    // Fill every lane, then a full lane stalls while the drop code still flows.
    for (int i = 0; i < 31; i++) cyc(1, 5'(i), 2'(i), '0, 0);
    chk("all_vld", out_vld, 31'h7FFF_FFFF);
    cyc(1, 5'd7, 2'b00, '0, 0);
    cyc(1, 5'd31, 2'b00, '0, 0);
    chk("full_drop_err", err, 1'b1);
    cyc(0, 5'd0, 2'b00, '1, 0);

    // Random traffic with random acks and occasional drops.
    for (int i = 0; i < 200; i++) begin
      logic [4:0]  s;
      logic [30:0] a;
      s = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      a = 31'($urandom) & 31'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), s, 2'($urandom), a, 0);
    end
    cyc(0, 5'd0, 2'b00, '1, 0);

`ifdef DEMUX_AUTOINC_EN
    // Pointer walks 0..30 and wraps; the 32nd word lands in lane 0.
    for (int i = 0; i < 32; i++) cyc(1, 5'd31, 2'(i + 1), '1, 1);
    chk("wrap_vld", out_vld, 31'h1);
    chk("wrap_dat", out_bus[1:0], 2'(32));
    // sel-mode traffic leaves the pointer untouched.
    cyc(1, 5'd20, 2'b10, '1, 0);
    cyc(1, 5'd31, 2'b11, '1, 1);
    chk("ptr_hold", out_vld, 31'h2);
    cyc(0, 5'd0, 2'b00, '1, 0);
`endif

    // Async reset between edges wipes everything at once.
    cyc(1, 5'd3, 2'b11, '0, 0);
    cyc(1, 5'd9, 2'b10, '0, 0);
    chk("pre_rst_vld", out_vld, 31'h208);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_vld", out_vld, 31'h0);
    chk("arst_bus", out_bus, 62'h0);
    chk("arst_cnt", err_cnt, 8'd0);
    chk("arst_err", err, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef DEMUX_AUTOINC_EN
    cyc(1, 5'd17, 2'b01, '0, 1);
    chk("post_rst_ptr", out_vld, 31'h1);
`else
    cyc(1, 5'd17, 2'b01, '0, 0);
    chk("post_rst_sel", out_vld, 31'h20000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_1to31_lane.md
# demux_1to31_lane

Registered 1-to-31 demultiplexer with per-lane valid/ack handshake: the inverse of the 31-input, 2-bit, 5-bit-select mux. A 2-bit word from a single producer is steered by `sel` into one of 31 lane hold registers. Each lane presents data and valid to its own consumer until that consumer acknowledges it. The block sits between a single upstream source and the per-lane consumers that feed the mux inputs.

## Interface
Parameters:
- `W`, default 2: lane data width.
- `NLANE`, default 31: number of lanes. Fixed at 31; lane index 31 is the reserved/illegal code.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `sel`  in  5  target lane, 0..30; 31 is illegal.
- `inp`  in  W  data word.
- `auto_mode`  in  1  use the internal pointer instead of `sel` (only with the auto-increment feature compiled in).
- `out_bus`  out  31*W  lane n data at bits [n*W+W-1 : n*W].
- `out_vld`  out  31  lane n holds unconsumed data.
- `out_ack`  in  31  consumer n takes lane n data.
- `err`  out  1  one-cycle pulse when a word addressed to lane 31 is dropped.
- `err_cnt`  out  8  saturating count of dropped words.

## Operation
Target lane `t`:
- `t` = `sel` when `auto_mode`=0.
- `t` = `ptr` when `auto_mode`=1 (auto-increment feature compiled in).

`in_ready` is combinational:
- Equals `~out_vld[t] | out_ack[t]` for `t` ≤ 30.
- Equals 1 when `t` = 31.

Transfer occurs when `in_valid & in_ready` are both high at a `clk` edge:
- If `t` ≤ 30: `lane[t]` ← `inp` and `out_vld[t]` ← 1.
- If `t` = 31: the word is dropped, `err` pulses for one cycle, and `err_cnt` increments, saturating at 255.

Lane consume: at an edge where `out_vld[n]` & `out_ack[n]` are both high, `out_vld[n]` ← 0, unless a transfer into lane n occurs on the same edge. In that case the lane reloads with the new data and `out_vld[n]` stays 1.

Other rules:
- `out_ack[n]` with `out_vld[n]`=0 is ignored.
- Lane data is held while valid and retains its last value after consume.
- Lanes are independent. A full lane stalls only producers targeting it.

## Timing
- Reset values: `out_bus`=0, `out_vld`=0, `err`=0, `err_cnt`=0, `ptr`=0.
- With `reset` asserted, `in_ready` reflects the empty lanes, i.e. 1, but no transfer is taken.
- Reset mid-operation clears all lanes, discarding pending data immediately, without waiting for a clock edge.
- Latency: data accepted at edge k appears on `out_bus` with `out_vld`=1 after edge k. That is one cycle, with no combinational path from `inp` to `out_bus`.
- Throughput: one word per cycle into distinct lanes, or into the same lane if its consumer acks every cycle.
- `in_valid` may drop without a transfer. `sel` and `inp` are sampled only on transfer.
- `err` is high for exactly the cycle after a dropped transfer. Consecutive drops hold `err` high continuously.
- `err_cnt` at 255 stays at 255 while `err` continues to pulse.

## Configuration
`DEMUX_AUTOINC_EN` defined:
- Adds the 5-bit `ptr` and the `auto_mode` input function.
- `ptr` advances on each transfer taken with `auto_mode`=1, wrapping 30 → 0.
- The pointer never produces 31, so there are no drops in auto mode.
- `ptr` is held when `auto_mode`=0.
- Toggling `auto_mode` does not reset `ptr`.

`DEMUX_AUTOINC_EN` not defined:
- No `ptr` register. `auto_mode` is ignored and `t` = `sel` always.
- The `auto_mode` port still exists and is tied off internally.

## Test plan
- Reset, then `sel`=5, `inp`=2'b10, `in_valid`=1 for one cycle → next cycle `out_vld`=31'h20 and `out_bus`[11:10]=2'b10; all other lanes remain 0.
- Lane 5 full, no ack, `sel`=5 → `in_ready`=0 and lane data unchanged. Assert `out_ack[5]` while driving `inp`=2'b01 → `in_ready`=1, lane 5 reloads to 01, and `out_vld[5]` stays 1.
- `sel`=31, `in_valid`=1 for 3 cycles → `err` high for 3 cycles, `err_cnt`=3, `out_vld` unchanged. Then 300 drops → `err_cnt`=255.
- Write lanes 0..30 with `inp` = index[1:0], no acks → all 31 `out_vld` bits set. Then `sel`=7 stalls (`in_ready`=0) while `sel`=31 still accepts and drops.
- With `DEMUX_AUTOINC_EN` defined, `auto_mode`=1, 32 back-to-back transfers with all `out_ack` high → lanes 0..30 each receive one word, and the 32nd word lands in lane 0 because `ptr` wraps.
- Fill lanes 3 and 9, then assert `reset` between clock edges → `out_vld`=0, `out_bus`=0, and `err_cnt`=0 immediately. The first transfer after deassertion targets lane 0 in auto mode.
